// File: rtl/au_cmp_seq_pkg.sv
// Shared types and result-vector bit positions for the sequential unsigned comparator.
package au_cmp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Bit order of the six-flag result vector
  localparam int unsigned RES_LT = 0;
  localparam int unsigned RES_GT = 1;
  localparam int unsigned RES_EQ = 2;
  localparam int unsigned RES_LE = 3;
  localparam int unsigned RES_GE = 4;
  localparam int unsigned RES_NE = 5;
  localparam int unsigned RES_W  = 6;

endpackage

// File: rtl/AU_cmp6_uns.sv
// Combinational WIDTH-bit unsigned comparator producing the six relational flags.
module AU_cmp6_uns
  import au_cmp_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [RES_W-1:0] res_c
);

  logic lt_c;
  logic eq_c;

  generate
    if (ARCH == 0) begin : g_rel
      assign lt_c = (a < b);
      assign eq_c = (a == b);
    end else begin : g_sub
      // Borrow out of a zero-extended subtract gives a<b
      logic [WIDTH:0] diff;
      assign diff = {1'b0, a} - {1'b0, b};
      assign lt_c = diff[WIDTH];
      assign eq_c = (diff[WIDTH-1:0] == '0);
    end
  endgenerate

  always_comb begin
    res_c         = '0;
    res_c[RES_LT] = lt_c;
    res_c[RES_GT] = ~lt_c & ~eq_c;
    res_c[RES_EQ] = eq_c;
    res_c[RES_LE] = lt_c | eq_c;
    res_c[RES_GE] = ~lt_c;
    res_c[RES_NE] = ~eq_c;
  end

endmodule

// File: rtl/au_cmp6_uns_seq.sv
// Multi-cycle NWORD*WIDTH-bit unsigned comparator: scans chunks MSB-first through one
// WIDTH-bit comparator, exits on the first unequal chunk, returns flags via valid/ready.
module au_cmp6_uns_seq
  import au_cmp_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NWORD = 4,
  parameter int unsigned ARCH  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NWORD*WIDTH-1:0]   a,
  input  logic [NWORD*WIDTH-1:0]   b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     lt,
  output logic                     gt,
  output logic                     eq,
  output logic                     le,
  output logic                     ge,
  output logic                     ne
);

  localparam int unsigned OPW  = NWORD * WIDTH;
  localparam int unsigned CNTW = (NWORD > 1) ? $clog2(NWORD) : 1;

  state_t           state;
  logic [OPW-1:0]   a_sh;
  logic [OPW-1:0]   b_sh;
  logic [CNTW-1:0]  cnt;
  logic [RES_W-1:0] res;
  logic [RES_W-1:0] chunk_res_c;

  AU_cmp6_uns #(
    .WIDTH(WIDTH),
    .ARCH (ARCH)
  ) u_cmp (
    .a    (a_sh[OPW-1 -: WIDTH]),
    .b    (b_sh[OPW-1 -: WIDTH]),
    .res_c(chunk_res_c)
  );

  // Control, operand shift registers and result flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res       <= '0;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            cnt      <= CNTW'(NWORD - 1);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          // The last chunk's flags are already the full-width answer when all chunks match
          if (chunk_res_c[RES_NE] || (cnt == '0)) begin
            res       <= chunk_res_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            a_sh <= a_sh << WIDTH;
            b_sh <= b_sh << WIDTH;
            cnt  <= cnt - CNTW'(1);
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lt = res[RES_LT];
  assign gt = res[RES_GT];
  assign eq = res[RES_EQ];
  assign le = res[RES_LE];
  assign ge = res[RES_GE];
  assign ne = res[RES_NE];

endmodule

// File: tb/tb_au_cmp6_uns_seq.sv
// Directed bench for au_cmp6_uns_seq: 32-bit (8x4) directed cases plus an exhaustive 4-bit (2x2) sweep.
module tb_au_cmp6_uns_seq;

  // Flag vectors packed as {ne,ge,le,eq,gt,lt}
  localparam logic [5:0] F_EQ = 6'b011100;
  localparam logic [5:0] F_GT = 6'b110010;
  localparam logic [5:0] F_LT = 6'b101001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8x4 instance
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [31:0] a1, b1;
  logic        lt1, gt1, eq1, le1, ge1, ne1;
  logic [5:0]  f1;
  assign f1 = {ne1, ge1, le1, eq1, gt1, lt1};

  au_cmp6_uns_seq #(.WIDTH(8), .NWORD(4), .ARCH(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .lt(lt1), .gt(gt1), .eq(eq1), .le(le1), .ge(ge1), .ne(ne1)
  );

  // 2x2 instance, subtract-based chunk comparator
  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [3:0]  a2, b2;
  logic        lt2, gt2, eq2, le2, ge2, ne2;
  logic [5:0]  f2;
  assign f2 = {ne2, ge2, le2, eq2, gt2, lt2};

  au_cmp6_uns_seq #(.WIDTH(2), .NWORD(2), .ARCH(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .lt(lt2), .gt(gt2), .eq(eq2), .le(le2), .ge(ge2), .ne(ne2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands in an IDLE cycle; returns in cycle c+1
  task automatic send1(input logic [31:0] av, input logic [31:0] bv);
    a1 = av;
    b1 = bv;
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
  endtask

  // Starting at cycle c+1, returns n such that out_valid rose in cycle c+n
  task automatic wait1(output int lat);
    lat = 1;
    while (!out_valid1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic wait2(output int lat);
    lat = 1;
    while (!out_valid2 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  function automatic logic [5:0] gold(input int x, input int y);
    return {x != y, x >= y, x <= y, x == y, x > y, x < y};
  endfunction

  initial begin
    int lat;
    int gap;
    rst_n = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    chk("rst_in_ready", 32'(in_ready1), 32'h1);
    chk("rst_out_valid", 32'(out_valid1), 32'h0);
    chk("rst_flags", 32'(f1), 32'h0);

    // Case 1: equal operands, all four chunks scanned; later input changes ignored
    send1(32'h12345678, 32'h12345678);
    chk("c1_in_ready_run", 32'(in_ready1), 32'h0);
    a1 = 32'h0;
    b1 = 32'hFFFFFFFF;
    wait1(lat);
    chk("c1_latency", 32'(lat), 32'd5);
    chk("c1_flags", 32'(f1), 32'(F_EQ));
    step();
    chk("c1_post_out_valid", 32'(out_valid1), 32'h0);
    chk("c1_post_in_ready", 32'(in_ready1), 32'h1);
    chk("c1_post_flags_hold", 32'(f1), 32'(F_EQ));

    // Case 2: top chunk decides
    send1(32'h80000000, 32'h7FFFFFFF);
    wait1(lat);
    chk("c2_latency", 32'(lat), 32'd2);
    chk("c2_flags", 32'(f1), 32'(F_GT));
    step();

    // Case 3: only the lowest chunk differs
    send1(32'h000000FE, 32'h000000FF);
    wait1(lat);
    chk("c3_latency", 32'(lat), 32'd5);
    chk("c3_flags", 32'(f1), 32'(F_LT));
    step();

    // Case 4: back-pressure on the result with new operands pending
    out_ready1 = 1'b0;
    send1(32'h80000000, 32'h7FFFFFFF);
    wait1(lat);
    chk("c4_latency", 32'(lat), 32'd2);
    a1 = 32'h00000001;
    b1 = 32'h00000002;
    in_valid1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("c4_hold_out_valid", 32'(out_valid1), 32'h1);
      chk("c4_hold_in_ready", 32'(in_ready1), 32'h0);
      chk("c4_hold_flags", 32'(f1), 32'(F_GT));
    end
    out_ready1 = 1'b1;
    step();
    chk("c4_idle_out_valid", 32'(out_valid1), 32'h0);
    chk("c4_idle_in_ready", 32'(in_ready1), 32'h1);
    chk("c4_idle_flags_hold", 32'(f1), 32'(F_GT));
    step();
    in_valid1 = 1'b0;
    chk("c4_new_accepted", 32'(in_ready1), 32'h0);
    wait1(lat);
    chk("c4_new_latency", 32'(lat), 32'd5);
    chk("c4_new_flags", 32'(f1), 32'(F_LT));
    step();

    // Case 5: reset in the middle of a scan, then a clean compare
    send1(32'h12345678, 32'h12345678);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("c5_rst_in_ready", 32'(in_ready1), 32'h1);
    chk("c5_rst_out_valid", 32'(out_valid1), 32'h0);
    chk("c5_rst_flags", 32'(f1), 32'h0);
    send1(32'h000000FE, 32'h000000FF);
    wait1(lat);
    chk("c5_after_latency", 32'(lat), 32'd5);
    chk("c5_after_flags", 32'(f1), 32'(F_LT));
    step();

    // Case 6: exhaustive 4-bit sweep with random idle gaps and result stalls
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) step();
        out_ready2 = 1'b0;
        a2 = 4'(x);
        b2 = 4'(y);
        in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        wait2(lat);
        chk("c6_latency", 32'(lat), ((x >> 2) != (y >> 2)) ? 32'd2 : 32'd3);
        chk("c6_flags", 32'(f2), 32'(gold(x, y)));
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) step();
        chk("c6_stall_valid", 32'(out_valid2), 32'h1);
        out_ready2 = 1'b1;
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
